// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants for the NTT datapath (q = 3329, Barrett k = 24).
package kyber_pkg;

    localparam int unsigned KYBER_Q   = 3329;
    localparam int unsigned KYBER_Q2  = 6658;
    localparam int unsigned BARRETT_K = 24;
    localparam int unsigned BARRETT_M = 5039;
    localparam int unsigned COEF_W    = 12;
    localparam int unsigned PROD_W    = 24;
    localparam int unsigned MAX_PROD  = 11075584;

endpackage

// File: rtl/modred_csub.sv
// Two-step conditional subtract: folds r in [0, 3q) down to [0, q).
module modred_csub
    import kyber_pkg::*;
(
    input  logic [13:0] r,
    output logic [11:0] res
);

    localparam logic [13:0] Q1 = 14'(KYBER_Q);
    localparam logic [13:0] Q2 = 14'(KYBER_Q2);

    logic [13:0] sel;

    always_comb begin
        sel = r;
        if (r >= Q2) begin
            sel = r - Q2;
        end else if (r >= Q1) begin
            sel = r - Q1;
        end
    end

    assign res = 12'(sel);

endmodule

// File: rtl/modred_barrett.sv
// Three-stage pipelined Barrett reducer, 24-bit product -> residue mod 3329.
// Optional sticky range flag enabled by defining MODRED_RANGE_CHK_EN.
module modred_barrett
    import kyber_pkg::*;
#(
    parameter int TAG_W   = 8,
    parameter int USE_DSP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_P,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_R,
    output logic [TAG_W-1:0]  out_tag,
    output logic              err_range
);

    logic             stall;
    logic             en;

    logic             s1_valid;
    logic [12:0]      s1_e;
    logic [13:0]      s1_p;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [13:0]      s2_r;
    logic [TAG_W-1:0] s2_tag;

    logic [12:0]      e_c;
    logic [13:0]      eq_c;
    logic [13:0]      r_c;
    logic [11:0]      res_c;

    // Global enable: the whole pipe freezes while the output is held.
    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    generate
        if (USE_DSP != 0) begin : g_dsp
            (* use_dsp = "yes" *) logic [12:0] e_mul;
            (* use_dsp = "yes" *) logic [13:0] eq_mul;
            assign e_mul  = 13'((37'(in_P) * 37'(BARRETT_M)) >> BARRETT_K);
            assign eq_mul = 14'(s1_e) * 14'(KYBER_Q);
            assign e_c    = e_mul;
            assign eq_c   = eq_mul;
        end else begin : g_gen
            assign e_c  = 13'((37'(in_P) * 37'(BARRETT_M)) >> BARRETT_K);
            assign eq_c = 14'(s1_e) * 14'(KYBER_Q);
        end
    endgenerate

    // True remainder is < 3q < 2^14, so arithmetic modulo 2^14 is exact.
    assign r_c = s1_p - eq_c;

    modred_csub u_csub (
        .r   (s2_r),
        .res (res_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_e      <= '0;
            s1_p      <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_R     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_e      <= e_c;
            s1_p      <= in_P[13:0];
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_r      <= r_c;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_R     <= res_c;
            out_tag   <= s2_tag;
        end
    end

`ifdef MODRED_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (in_valid && in_ready && (in_P > 24'(MAX_PROD))) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_modred_barrett.sv
// Scoreboard bench for modred_barrett: reference residue is plain p % 3329.
module tb_modred_barrett;

    localparam int TAG_W = 8;
    localparam int Q     = 3329;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [23:0]       in_P = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [11:0]       out_R;
    logic [TAG_W-1:0]  out_tag;
    logic              err_range;

    modred_barrett #(.TAG_W(TAG_W), .USE_DSP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_P      (in_P),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_R     (out_R),
        .out_tag   (out_tag),
        .err_range (err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               res;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_in = 0;
    bit   lat_chk = 1'b0;
    bit   rnd_rdy = 1'b0;
    bit   exp_err = 1'b0;
    bit   send_done = 1'b0;

`ifdef MODRED_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Random backpressure source, active only in the bubble phase.
    always @(negedge clk) if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));

    // Monitor: samples well after all negedge drivers have settled.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_tag", out_tag, e.tag);
                    check("out_R", out_R, e.res);
                    if (lat_chk) check("latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    task automatic send(input logic [23:0] p, input logic [TAG_W-1:0] tg);
        int budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_P     = p;
        in_tag   = tg;
        #1;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            check("send_timeout", 1, 0);
        end else begin
            e.tag = tg;
            e.res = int'(p) % Q;
            e.cyc = cyc;
            sb.push_back(e);
            n_in++;
            if (RCHK && p > 24'd11075584) exp_err = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_R", out_R, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_err_range", err_range, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Range boundary: (q-1)^2 is legal, one above is flagged
        send(24'd11075584, 8'd90);
        idle();
        check("range_at_max", err_range, 0);
        send(24'd11075585, 8'd91);
        idle();
        check("range_above_max", err_range, RCHK);
        repeat (4) @(negedge clk);
        check("range_sticky", err_range, RCHK);
        drain("drain_range");

        // Corner values back-to-back, latency checked
        lat_chk = 1'b1;
        send(24'd0, 8'd10);
        send(24'd3328, 8'd11);
        send(24'd3329, 8'd12);
        send(24'd11075584, 8'd13);
        send(24'd16777215, 8'd14);
        idle();
        drain("drain_corner");

        // Random sweep at full throughput
        for (int i = 0; i < 2000; i++) send(24'($urandom), 8'(i));
        idle();
        drain("drain_sweep");
        lat_chk = 1'b0;
        check("sweep_err_range", err_range, exp_err);

        // Backpressure: four operands queued behind a held output
        out_ready = 1'b0;
        send_done = 1'b0;
        fork
            begin
                send(24'd10000, 8'd1);
                send(24'd20000, 8'd2);
                send(24'd30000, 8'd3);
                send(24'd40000, 8'd4);
                idle();
                send_done = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_held_tag", out_tag, 1);
        @(negedge clk);
        out_ready = 1'b1;
        for (int b = 0; b < 50 && !send_done; b++) @(negedge clk);
        check("bp_send_done", send_done, 1);
        drain("drain_bp");

        // Bubbles with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(24'($urandom), 8'(100 + i));
            idle();
        end
        rnd_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain("drain_bubble");
        check("in_out_count", n_out, n_in);

        // Reset with three operands in flight
        send(24'd5000, 8'd20);
        send(24'd6000, 8'd21);
        send(24'd7000, 8'd22);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_err_range", err_range, 0);
        n_in = n_in - sb.size();
        sb.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stale_output", out_valid, 0);
        lat_chk = 1'b1;
        send(24'd6659, 8'd33);
        idle();
        drain("drain_post_rst");
        check("final_err_range", err_range, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
